clause_stream_memory: RTL

CLAUSE_STREAM_MEMORY -- requirements
Module: clause_stream_memory

---
 rtl/clause_stream_memory.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/clause_stream_memory.sv
// Clause store with row-wide streaming readout over a valid/ready port.
// Supports one-shot or looping streams, and a clamped active-clause count with a partial final-row mask.
module clause_stream_memory #(
  parameter int unsigned NUM_CLAUSES           = 64,
  parameter int unsigned VAR_ID_BITS           = 8,
  parameter int unsigned NUM_VARS_PER_CLAUSE   = 3,
  parameter int unsigned NUM_CLAUSES_PER_CYCLE = 16,
  localparam int unsigned CLAUSE_BITS = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE,
  localparam int unsigned NUM_ROWS    = (NUM_CLAUSES + NUM_CLAUSES_PER_CYCLE - 1) / NUM_CLAUSES_PER_CYCLE,
  localparam int unsigned ROW_BITS    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned ADDR_W      = $clog2(NUM_CLAUSES),
  localparam int unsigned CNT_W       = $clog2(NUM_CLAUSES + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          wr_en,
  input  logic [ADDR_W-1:0]                             wr_addr,
  input  logic [CLAUSE_BITS-1:0]                        wr_clause,
  output logic                                          wr_reject,
  input  logic                                          start,
  input  logic [CNT_W-1:0]                              num_active,
  input  logic                                          loop_mode,
  input  logic                                          stop,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [CLAUSE_BITS*NUM_CLAUSES_PER_CYCLE-1:0]  output_memory_slice,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0]              out_mask,
  output logic [ROW_BITS-1:0]                           out_row,
  output logic                                          out_last,
  output logic                                          busy,
  output logic                                          done
);

  localparam int unsigned NCPC    = NUM_CLAUSES_PER_CYCLE;
  localparam int unsigned SLICE_W = CLAUSE_BITS * NCPC;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t state_q, state_d;

  logic [CLAUSE_BITS-1:0] mem [NUM_CLAUSES];

  logic [ROW_BITS-1:0] last_row_q;
  logic [NCPC-1:0]     last_mask_q;
  logic                loop_q;
  logic                stop_q;

  logic [CNT_W-1:0]    clamped;
  logic [31:0]         rows_in;
  logic [31:0]         rem_in;
  logic [ROW_BITS-1:0] last_row_in;
  logic [NCPC-1:0]     last_mask_in;

  logic                accept;
  logic                end_now;
  logic                addr_ok;

  logic                load;
  logic                ctx_load;
  logic [ROW_BITS-1:0] row_sel;
  logic                valid_d;
  logic                done_d;
  logic                last_d;
  logic [NCPC-1:0]     mask_d;
  logic [SLICE_W-1:0]  slice_d;

  // Decode the stream geometry from num_active as it is sampled on start
  always_comb begin
    clamped     = (32'(num_active) > NUM_CLAUSES) ? CNT_W'(NUM_CLAUSES) : num_active;
    rows_in     = (32'(clamped) + NCPC - 1) / NCPC;
    last_row_in = ROW_BITS'(rows_in - 1);
    rem_in      = 32'(clamped) - (rows_in - 1) * NCPC;
    for (int unsigned j = 0; j < NCPC; j++) begin
      last_mask_in[j] = (j < rem_in);
    end
  end

  assign accept  = out_valid & out_ready;
  assign end_now = loop_q ? (stop_q | stop) : out_last;
  assign addr_ok = (32'(wr_addr) < NUM_CLAUSES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && clamped != '0) state_d = STREAM;
      STREAM:  if (accept && end_now)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    ctx_load = 1'b0;
    row_sel  = out_row;
    valid_d  = out_valid;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (clamped == '0) begin
            done_d = 1'b1;
          end else begin
            load     = 1'b1;
            ctx_load = 1'b1;
            row_sel  = '0;
            valid_d  = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          if (end_now) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            load    = 1'b1;
            row_sel = out_last ? '0 : out_row + 1'b1;
          end
        end
      end
      default: ;
    endcase
    last_d = (row_sel == (ctx_load ? last_row_in : last_row_q));
    mask_d = last_d ? (ctx_load ? last_mask_in : last_mask_q) : '1;
  end

  // Slot read for the row about to be presented; masked-off and out-of-range slots read zero
  for (genvar j = 0; j < NCPC; j++) begin : g_slot
    logic [31:0] idx;
    assign idx = 32'(row_sel) * NCPC + 32'(j);
    assign slice_d[j*CLAUSE_BITS +: CLAUSE_BITS] =
      (mask_d[j] && idx < NUM_CLAUSES) ? mem[ADDR_W'(idx)] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && state_q == IDLE && addr_ok) begin
      mem[wr_addr] <= wr_clause;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid           <= 1'b0;
      done                <= 1'b0;
      busy                <= 1'b0;
      wr_reject           <= 1'b0;
      out_row             <= '0;
      out_last            <= 1'b0;
      out_mask            <= '0;
      output_memory_slice <= '0;
      last_row_q          <= '0;
      last_mask_q         <= '0;
      loop_q              <= 1'b0;
      stop_q              <= 1'b0;
    end else begin
      out_valid <= valid_d;
      done      <= done_d;
      busy      <= (state_d == STREAM);
      wr_reject <= wr_en && (state_q == STREAM || !addr_ok);
      if (load) begin
        out_row             <= row_sel;
        out_last            <= last_d;
        out_mask            <= mask_d;
        output_memory_slice <= slice_d;
      end
      if (ctx_load) begin
        last_row_q  <= last_row_in;
        last_mask_q <= last_mask_in;
        loop_q      <= loop_mode;
      end
      // Stop only matters for looping streams; it is consumed when the stream ends
      if (ctx_load || (state_q == STREAM && accept && end_now)) begin
        stop_q <= 1'b0;
      end else if (state_q == STREAM && loop_q && stop) begin
        stop_q <= 1'b1;
      end
    end
  end

endmodule
